// File: rtl/vec_length.sv
// Iterative Euclidean length: sums x^2+y^2+z^2 on one shared multiplier, then a
// restoring square root, one result bit per cycle. direction packs {x, y, z}, x in the MSBs.
module vec_length #(
   parameter int WIDTH  = 16,
   parameter int Q_BITS = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [3*WIDTH-1:0]   direction,
   output logic                 ready,
   output logic                 valid,
   output logic [WIDTH-1:0]     len,
   output logic [3*WIDTH-1:0]   direction_out,
   output logic                 zero,
   output logic                 saturated
);

   localparam int SW = 2*WIDTH + 2;
   localparam int RW = WIDTH + 4;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] LEN_MAX = {1'b0, {(WIDTH-1){1'b1}}};

   // S carries 2*Q_BITS fractional bits, so its root lands on Q_BITS with no realignment.
   if (Q_BITS < 0 || Q_BITS >= WIDTH) begin : g_bad_q
      $error("vec_length: Q_BITS must lie in [0, WIDTH-1]");
   end

   typedef enum logic [1:0] {IDLE, SQUARE, SQRT, DONE} state_t;

   state_t                   state;
   logic [1:0]               sel;
   logic [SW-1:0]            acc;
   logic [SW-1:0]            acc_next;
   logic [SW-1:0]            rad;
   logic [WIDTH+1:0]         rem;
   logic [WIDTH:0]           root;
   logic [WIDTH:0]           root_next;
   logic [CW-1:0]            cnt;
   logic signed [WIDTH-1:0]  comp;
   logic signed [2*WIDTH-1:0] sq;
   logic [RW-1:0]            rem_sh;
   logic [RW-1:0]            trial;
   logic [RW-1:0]            diff;
   logic [RW-1:0]            rem_next;
   logic                     take;
   logic [1:0]               rem_unused;

   always_comb begin
      case (sel)
         2'd0:    comp = direction_out[3*WIDTH-1 -: WIDTH];
         2'd1:    comp = direction_out[2*WIDTH-1 -: WIDTH];
         default: comp = direction_out[WIDTH-1:0];
      endcase
      // A square is never negative, so the signed product is reused as unsigned.
      sq       = comp * comp;
      acc_next = acc + {2'b00, sq};

      rem_sh    = {rem, rad[SW-1 -: 2]};
      trial     = {1'b0, root, 2'b01};
      take      = (rem_sh >= trial);
      diff      = rem_sh - trial;
      rem_next  = take ? diff : rem_sh;
      root_next = {root[WIDTH-1:0], take};
      // The remainder never exceeds 2*root, so these top bits are always zero.
      rem_unused = rem_next[RW-1 -: 2];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         ready         <= 1'b1;
         valid         <= 1'b0;
         len           <= '0;
         direction_out <= '0;
         zero          <= 1'b0;
         saturated     <= 1'b0;
         sel           <= '0;
         acc           <= '0;
         rad           <= '0;
         rem           <= '0;
         root          <= '0;
         cnt           <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  direction_out <= direction;
                  acc           <= '0;
                  sel           <= '0;
                  ready         <= 1'b0;
                  state         <= SQUARE;
               end
            end
            SQUARE: begin
               acc <= acc_next;
               sel <= sel + 2'd1;
               if (sel == 2'd2) begin
                  rad   <= acc_next;
                  rem   <= '0;
                  root  <= '0;
                  cnt   <= '0;
                  state <= SQRT;
               end
            end
            SQRT: begin
               rad  <= {rad[SW-3:0], 2'b00};
               rem  <= rem_next[WIDTH+1:0];
               root <= root_next;
               cnt  <= cnt + CW'(1);
               if (cnt == CW'(WIDTH)) begin
                  if (|root_next[WIDTH:WIDTH-1]) begin
                     len       <= LEN_MAX;
                     saturated <= 1'b1;
                  end else begin
                     len       <= root_next[WIDTH-1:0];
                     saturated <= 1'b0;
                  end
                  zero  <= (acc == '0);
                  valid <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               valid <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vec_length.sv
// Randomized and directed bench for vec_length against an arithmetic length model.
module tb_vec_length;

   localparam int W      = 16;
   localparam int Q      = 12;
   localparam int LAT    = W + 5;
   localparam int PERIOD = W + 6;
   localparam int LMAX   = (1 << (W-1)) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [3*W-1:0]   direction = '0;
   logic             ready;
   logic             valid;
   logic [W-1:0]     len;
   logic [3*W-1:0]   direction_out;
   logic             zero;
   logic             saturated;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   vec_length #(.WIDTH(W), .Q_BITS(Q)) dut (
      .clk(clk), .reset(reset), .start(start), .direction(direction),
      .ready(ready), .valid(valid), .len(len), .direction_out(direction_out),
      .zero(zero), .saturated(saturated)
   );

   function automatic logic [3*W-1:0] pack(input int x, input int y, input int z);
      logic [W-1:0] px, py, pz;
      px = W'(x);
      py = W'(y);
      pz = W'(z);
      return {px, py, pz};
   endfunction

   function automatic longint isqrt(input longint s);
      longint r;
      r = longint'($sqrt(real'(s)));
      while (r * r > s) r--;
      while ((r + 1) * (r + 1) <= s) r++;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ready"}, 64'(ready), 64'(1));
      chk({tag, "_valid"}, 64'(valid), 64'(0));
      chk({tag, "_len"}, 64'(len), 64'(0));
      chk({tag, "_dir"}, 64'(direction_out), 64'(0));
      chk({tag, "_zero"}, 64'(zero), 64'(0));
      chk({tag, "_sat"}, 64'(saturated), 64'(0));
   endtask

   // One accepted request; at cycle inj (if >0) a stray start with another vector is pulsed.
   task automatic run_vec(input int x, input int y, input int z, input int inj);
      longint s, r;
      int     cyc;
      logic [3*W-1:0] d;
      d = pack(x, y, z);
      s = longint'(x)*x + longint'(y)*y + longint'(z)*z;
      r = isqrt(s);
      @(negedge clk);
      direction = d;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("accept_ready_low", 64'(ready), 64'(0));
      chk("accept_dir_out", 64'(direction_out), 64'(d));
      cyc = 1;
      while (valid !== 1'b1 && cyc < 4*LAT) begin
         if (cyc == inj) begin
            direction = pack(-x + 7, y + 3, 12345);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      chk("latency", 64'(cyc), 64'(LAT));
      chk("len", 64'(len), 64'((r > LMAX) ? LMAX : r));
      chk("zero", 64'(zero), 64'(s == 0));
      chk("saturated", 64'(saturated), 64'(r > LMAX));
      chk("dir_out_at_valid", 64'(direction_out), 64'(d));
      @(posedge clk); #1;
      chk("valid_pulse_end", 64'(valid), 64'(0));
      chk("ready_after_done", 64'(ready), 64'(1));
      chk("len_hold", 64'(len), 64'((r > LMAX) ? LMAX : r));
   endtask

   initial begin
      logic signed [W-1:0] rx, ry, rz;
      int cyc, nval;

      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset_init");
      @(negedge clk);
      reset = 1'b1;

      run_vec(4096, 0, 0, 0);
      run_vec(12288, 16384, 0, 0);
      run_vec(-12288, 0, -16384, 0);
      run_vec(2048, 2048, 2048, 0);
      run_vec(1, 1, 1, 0);
      run_vec(0, 0, 0, 0);
      run_vec(-32768, -32768, -32768, 0);
      run_vec(32767, 0, 0, 0);
      run_vec(-32768, 0, 0, 0);

      for (int i = 0; i < 12; i++) begin
         rx = W'($urandom);
         ry = W'($urandom);
         rz = W'($urandom);
         if (i < 4) begin
            rx = rx >>> 3;
            ry = ry >>> 3;
            rz = rz >>> 3;
         end
         run_vec(int'(rx), int'(ry), int'(rz), 0);
      end

      // Stray start while busy must be ignored.
      run_vec(12288, 16384, 0, 5);

      // Back-to-back with start held high.
      @(negedge clk);
      direction = pack(4096, 0, 0);
      start = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (valid !== 1'b1 && cyc < 4*PERIOD);
      chk("b2b_first_valid", 64'(valid), 64'(1));
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (valid !== 1'b1 && cyc < 4*PERIOD);
      chk("b2b_period", 64'(cyc), 64'(PERIOD));
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (ready !== 1'b1 && cyc < 4*PERIOD) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("b2b_idle", 64'(ready), 64'(1));

      // Reset asserted mid-computation.
      @(negedge clk);
      direction = pack(12288, 16384, 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < 10; c++) begin
         @(posedge clk); #1;
      end
      reset = 1'b0;
      #1;
      check_reset_vals("reset_mid");
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset_held");
      @(negedge clk);
      reset = 1'b1;
      nval = 0;
      for (int c = 0; c < 2*LAT; c++) begin
         @(posedge clk); #1;
         if (valid === 1'b1) nval++;
      end
      chk("no_valid_after_abort", 64'(nval), 64'(0));
      chk("ready_after_abort", 64'(ready), 64'(1));
      run_vec(4096, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
